chroma_shift_sched: RTL and testbench

- Sequencer for the per-channel line-offset (chroma shift) datapath on the 32-bit YCbCr422 stream (4 bytes per word).
- Tracks word/line/frame position and owns the enable state machine.
- Latches runtime G/B line delays at frame boundaries.
- Generates the R/G/B line-buffer FIFO write/read strobes, black-line select and occupancy/error status, replacing hardcoded line windows.

---
 rtl/chroma_shift_sched_pkg.sv | 36 +++
 rtl/chroma_shift_sched_occ.sv | 56 +++++
 rtl/chroma_shift_sched.sv | 210 +++++++++++++++++++++
 tb/tb_chroma_shift_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_shift_sched_pkg.sv
// chroma_shift_sched_pkg
//   Shared constants for the chroma-shift sequencer: stream geometry, FIFO
//   depths, FSM state encoding, err bit positions and the shadow-delay type.
package chroma_shift_sched_pkg;

    localparam int LINE_WORDS  = 160;
    localparam int FRAME_LINES = 403;
    localparam int G_DEPTH     = 1024;
    localparam int B_DEPTH     = 2048;
    localparam int DLY_W       = 2;

    localparam int WORD_W      = 8;
    localparam int LINE_W      = 10;
    localparam int G_OCC_W     = 11;
    localparam int B_OCC_W     = 12;

    localparam logic [1:0] ST_BYPASS = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_PRIME  = 2'd2;
    localparam logic [1:0] ST_STREAM = 2'd3;

    localparam int ERR_OVR   = 0;
    localparam int ERR_UDR   = 1;
    localparam int ERR_CFG   = 2;
    localparam int ERR_DRIFT = 3;

    typedef struct packed {
        logic [DLY_W-1:0] g;
        logic [DLY_W-1:0] b;
    } dly_pair_t;

    function automatic logic [LINE_W-1:0] dly_ext(input logic [DLY_W-1:0] d);
        return LINE_W'(d);
    endfunction

endpackage

// File: rtl/chroma_shift_sched_occ.sv
// line_fifo_occ
//   Occupancy tracker for one line-buffer FIFO, with overrun/underrun event
//   detection and a synchronous clear.
//   clk, rst   : clock, async active-high reset
//   wr_i, rd_i : FIFO write / read strobes
//   clr_i      : zero the occupancy at this edge (flush)
//   occ_o      : current occupancy
//   occ_nxt_o  : occupancy after this cycle's strobes, before any clear
//   ovr_o      : write attempted at full (write suppressed)
//   udr_o      : read attempted at empty (read suppressed)
module line_fifo_occ #(
    parameter int W     = 11,
    parameter int DEPTH = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_i,
    input  logic         rd_i,
    input  logic         clr_i,
    output logic [W-1:0] occ_o,
    output logic [W-1:0] occ_nxt_o,
    output logic         ovr_o,
    output logic         udr_o
);
    logic [W-1:0] occ_q, occ_d;
    logic         full, empty;

    assign full  = (occ_q == W'(DEPTH));
    assign empty = (occ_q == '0);

    always_comb begin
        occ_d = occ_q;
        ovr_o = 1'b0;
        udr_o = 1'b0;
        if (rd_i && empty) begin
            // The read is dropped; a write in the same cycle still lands.
            udr_o = 1'b1;
            if (wr_i) occ_d = occ_q + 1'b1;
        end else if (wr_i && !rd_i) begin
            if (full) ovr_o = 1'b1;
            else      occ_d = occ_q + 1'b1;
        end else if (rd_i && !wr_i) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        occ_q <= '0;
        else if (clr_i) occ_q <= '0;
        else            occ_q <= occ_d;
    end

    assign occ_o     = occ_q;
    assign occ_nxt_o = occ_d;

endmodule

// File: rtl/chroma_shift_sched.sv
// chroma_shift_sched
//   Sequencer for the per-channel line-offset datapath on the 32-bit YCbCr422
//   stream. Tracks word/line position, owns the enable FSM, latches G/B line
//   delays at frame boundaries and drives the G/B FIFO strobes and status.
//   Inputs : clk, rst (async, active-high), en (async), cfg_g_dly, cfg_b_dly,
//            err_clr, vld_i, ds_rdy, eof_i
//   Outputs: active, black_line, r_use, g_wr, b_wr, g_rd, b_rd, fifo_flush,
//            line_cnt, g_occ, b_occ, err {drift,cfg,underrun,overrun},
//            frame_cnt, err_evt_cnt
//   Build option: CHROMA_SCHED_STATS_EN enables the frame / error-event
//   counters; without it both stat ports are tied to zero.
//
//   state  | meaning
//   BYPASS | passthrough, waiting for synchronised enable
//   ARMED  | enabled, waiting for a frame boundary to start cleanly
//   PRIME  | shifting, output lines are black until B delay is covered
//   STREAM | shifting, R/G/B all live
module chroma_shift_sched
    import chroma_shift_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DLY_W-1:0]   cfg_g_dly,
    input  logic [DLY_W-1:0]   cfg_b_dly,
    input  logic               err_clr,
    input  logic               vld_i,
    input  logic               ds_rdy,
    input  logic               eof_i,
    output logic               active,
    output logic               black_line,
    output logic               r_use,
    output logic               g_wr,
    output logic               b_wr,
    output logic               g_rd,
    output logic               b_rd,
    output logic               fifo_flush,
    output logic [LINE_W-1:0]  line_cnt,
    output logic [G_OCC_W-1:0] g_occ,
    output logic [B_OCC_W-1:0] b_occ,
    output logic [3:0]         err,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        err_evt_cnt
);
    logic                xfer, eol, eof, act;
    logic                en_meta_q, en_s_q;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic [1:0]          state_q, state_d;
    dly_pair_t           shadow_q, shadow_d;
    logic                latch, cfg_bad, drift, flush_now, flush_q;
    logic [3:0]          err_q, err_d, err_set;
    logic [LINE_W-1:0]   g_ext, b_ext;
    logic                b_win, g_win, r_win;
    logic [G_OCC_W-1:0]  g_occ_nxt;
    logic [B_OCC_W-1:0]  b_occ_nxt;
    logic                g_ovr, g_udr, b_ovr, b_udr;

    assign xfer = vld_i & ds_rdy;
    assign eol  = xfer && (word_cnt_q == WORD_W'(LINE_WORDS - 1));
    assign eof  = xfer & eof_i;
    assign act  = state_q[1];   // PRIME and STREAM

    always_comb begin
        // A frame end also realigns the word position, so a short last line
        // cannot skew the next frame's line boundaries.
        word_cnt_d = word_cnt_q;
        if (eof || eol)  word_cnt_d = '0;
        else if (xfer)   word_cnt_d = word_cnt_q + 1'b1;

        line_cnt_d = line_cnt_q;
        if (eof)
            line_cnt_d = '0;
        else if (eol && (line_cnt_q != LINE_W'(FRAME_LINES - 1)))
            line_cnt_d = line_cnt_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            ST_BYPASS: if (en_s_q) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!en_s_q)  state_d = ST_BYPASS;
                else if (eof) latch   = 1'b1;
            end
            default: begin
                if (eof) begin
                    if (en_s_q) latch   = 1'b1;
                    else        state_d = ST_BYPASS;
                end else if (state_q == ST_PRIME && eol &&
                             line_cnt_d == dly_ext(shadow_q.b)) begin
                    state_d = ST_STREAM;
                end
            end
        endcase

        cfg_bad  = latch && (cfg_g_dly > cfg_b_dly);
        shadow_d = shadow_q;
        if (latch && !cfg_bad) begin
            shadow_d.g = cfg_g_dly;
            shadow_d.b = cfg_b_dly;
        end
        if (latch) state_d = (shadow_d.b == '0) ? ST_STREAM : ST_PRIME;
    end

    assign g_ext = dly_ext(shadow_q.g);
    assign b_ext = dly_ext(shadow_q.b);
    assign b_win = line_cnt_q < (LINE_W'(FRAME_LINES) - b_ext);
    assign g_win = (line_cnt_q >= (b_ext - g_ext)) &&
                   (line_cnt_q < (LINE_W'(FRAME_LINES) - g_ext));
    assign r_win = line_cnt_q >= b_ext;

    assign b_wr  = act & xfer & b_win;
    assign g_wr  = act & xfer & g_win;
    assign r_use = act & xfer & r_win;
    assign g_rd  = r_use;
    assign b_rd  = r_use;

    line_fifo_occ #(.W(G_OCC_W), .DEPTH(G_DEPTH)) u_g_occ (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (g_wr),
        .rd_i      (g_rd),
        .clr_i     (flush_now),
        .occ_o     (g_occ),
        .occ_nxt_o (g_occ_nxt),
        .ovr_o     (g_ovr),
        .udr_o     (g_udr)
    );

    line_fifo_occ #(.W(B_OCC_W), .DEPTH(B_DEPTH)) u_b_occ (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (b_wr),
        .rd_i      (b_rd),
        .clr_i     (flush_now),
        .occ_o     (b_occ),
        .occ_nxt_o (b_occ_nxt),
        .ovr_o     (b_ovr),
        .udr_o     (b_udr)
    );

    // Drift looks at occupancy including this cycle's final read/write.
    assign drift     = eof && (state_q == ST_STREAM) &&
                       ((g_occ_nxt != '0) || (b_occ_nxt != '0));
    assign flush_now = drift || ((state_d == ST_BYPASS) && (state_q != ST_BYPASS));

    always_comb begin
        err_set            = '0;
        err_set[ERR_OVR]   = g_ovr | b_ovr;
        err_set[ERR_UDR]   = g_udr | b_udr;
        err_set[ERR_CFG]   = cfg_bad;
        err_set[ERR_DRIFT] = drift;
        err_d = (err_clr ? 4'b0000 : err_q) | err_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_meta_q  <= 1'b0;
            en_s_q     <= 1'b0;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            state_q    <= ST_BYPASS;
            shadow_q   <= '{g: DLY_W'(1), b: DLY_W'(3)};
            err_q      <= '0;
            flush_q    <= 1'b0;
        end else begin
            en_meta_q  <= en;
            en_s_q     <= en_meta_q;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            err_q      <= err_d;
            flush_q    <= flush_now;
        end
    end

    assign active     = act;
    assign black_line = (state_q == ST_PRIME);
    assign fifo_flush = flush_q;
    assign line_cnt   = line_cnt_q;
    assign err        = err_q;

`ifdef CHROMA_SCHED_STATS_EN
    logic [15:0] frame_cnt_q, err_evt_cnt_q;
    logic [15:0] evt_n;

    assign evt_n = 16'(g_ovr) + 16'(b_ovr) + 16'(g_udr) + 16'(b_udr) +
                   16'(cfg_bad) + 16'(drift);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            err_evt_cnt_q <= '0;
        end else begin
            if (eof && act) frame_cnt_q <= frame_cnt_q + 16'd1;
            err_evt_cnt_q <= err_evt_cnt_q + evt_n;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign err_evt_cnt = err_evt_cnt_q;
`else
    assign frame_cnt   = '0;
    assign err_evt_cnt = '0;
`endif

endmodule

// File: tb/tb_chroma_shift_sched.sv
module tb_chroma_shift_sched;

    logic        clk = 1'b0;
    logic        rst, en, err_clr, vld_i, ds_rdy, eof_i;
    logic [1:0]  cfg_g_dly, cfg_b_dly;
    logic        active, black_line, r_use, g_wr, b_wr, g_rd, b_rd, fifo_flush;
    logic [9:0]  line_cnt;
    logic [10:0] g_occ;
    logic [11:0] b_occ;
    logic [3:0]  err;
    logic [15:0] frame_cnt, err_evt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [6:0] flags;   // active, black, r_use, g_wr, b_wr, g_rd, b_rd
        logic [9:0] line;
    } exp_t;
    exp_t sb_q[$];

    // Expected-behaviour model of the frame being sent.
    bit m_act;
    int m_g, m_b, m_line, m_word;
    int pk_g, pk_b;

    always #5 clk = ~clk;

    chroma_shift_sched dut (
        .clk(clk), .rst(rst), .en(en), .cfg_g_dly(cfg_g_dly), .cfg_b_dly(cfg_b_dly),
        .err_clr(err_clr), .vld_i(vld_i), .ds_rdy(ds_rdy), .eof_i(eof_i),
        .active(active), .black_line(black_line), .r_use(r_use), .g_wr(g_wr),
        .b_wr(b_wr), .g_rd(g_rd), .b_rd(b_rd), .fifo_flush(fifo_flush),
        .line_cnt(line_cnt), .g_occ(g_occ), .b_occ(b_occ), .err(err),
        .frame_cnt(frame_cnt), .err_evt_cnt(err_evt_cnt)
    );

    task automatic drive_word(input bit last, input bit clr);
        exp_t e, got;
        logic [6:0] fl;
        vld_i = 1'b1; ds_rdy = 1'b1; eof_i = last; err_clr = clr;
        fl[6] = m_act;
        fl[5] = m_act && (m_line < m_b);
        fl[4] = m_act && (m_line >= m_b);
        fl[3] = m_act && (m_line >= m_b - m_g) && (m_line < 403 - m_g);
        fl[2] = m_act && (m_line < 403 - m_b);
        fl[1] = fl[4];
        fl[0] = fl[4];
        e.flags = fl;
        e.line  = 10'(m_line);
        sb_q.push_back(e);
        @(negedge clk);
        got = {active, black_line, r_use, g_wr, b_wr, g_rd, b_rd, line_cnt};
        e = sb_q.pop_front();
        if (n_bad < 40) begin
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL word_strobes l%0d w%0d: got flags=%b line=%0d, want flags=%b line=%0d",
                         m_line, m_word, got.flags, got.line, e.flags, e.line);
            end
        end
        if (int'(g_occ) > pk_g) pk_g = int'(g_occ);
        if (int'(b_occ) > pk_b) pk_b = int'(b_occ);
        if (last) begin
            m_line = 0; m_word = 0;
        end else if (m_word == 159) begin
            m_word = 0;
            if (m_line < 402) m_line++;
        end else begin
            m_word++;
        end
        @(posedge clk); #1;
        vld_i = 1'b0; eof_i = 1'b0; err_clr = 1'b0;
    endtask

    task automatic send_words(input int n, input bit eof_last, input bit clr_last);
        for (int i = 0; i < n; i++)
            drive_word(eof_last && (i == n - 1), clr_last && (i == n - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; vld_i = 1'b0; ds_rdy = 1'b0; eof_i = 1'b0;
        err_clr = 1'b0; cfg_g_dly = 2'd1; cfg_b_dly = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({active, black_line, r_use, g_wr, b_wr, g_rd, b_rd, fifo_flush} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {active, black_line, r_use, g_wr, b_wr, g_rd, b_rd, fifo_flush});
        end
        n_cmp++;
        if (line_cnt !== 10'd0) begin
            n_bad++; $display("FAIL reset_line: got %0d want 0", line_cnt);
        end
        n_cmp++;
        if ({g_occ, b_occ} !== 23'd0) begin
            n_bad++; $display("FAIL reset_occ: got g=%0d b=%0d want 0/0", g_occ, b_occ);
        end
        n_cmp++;
        if (err !== 4'b0000) begin
            n_bad++; $display("FAIL reset_err: got %b want 0000", err);
        end
        n_cmp++;
        if ({frame_cnt, err_evt_cnt} !== 32'd0) begin
            n_bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", frame_cnt, err_evt_cnt);
        end
        rst = 1'b0;
        idle(4);
        n_cmp++;
        if (active !== 1'b0) begin
            n_bad++; $display("FAIL armed_inactive: got %b want 0", active);
        end
        m_act = 1'b0; m_g = 1; m_b = 3; m_line = 0; m_word = 0;
        send_words(160, 1'b1, 1'b0);
        m_act = 1'b1;
        n_cmp++;
        if ({active, black_line} !== 2'b11) begin
            n_bad++; $display("FAIL armed_to_prime: got %b want 11", {active, black_line});
        end
    endtask

    task automatic test_full_frame();
        pk_g = 0; pk_b = 0;
        for (int l = 0; l < 403; l++) begin
            if (l == 100) cfg_g_dly = 2'd2;
            send_words(160, l == 402, 1'b0);
        end
        n_cmp++;
        if (pk_g != 160) begin
            n_bad++; $display("FAIL g_peak: got %0d want 160", pk_g);
        end
        n_cmp++;
        if (pk_b != 480) begin
            n_bad++; $display("FAIL b_peak: got %0d want 480", pk_b);
        end
        n_cmp++;
        if ({g_occ, b_occ, err, fifo_flush} !== 28'd0) begin
            n_bad++;
            $display("FAIL full_frame_end: got g=%0d b=%0d err=%b flush=%b want 0/0/0000/0",
                     g_occ, b_occ, err, fifo_flush);
        end
        n_cmp++;
        if ({active, black_line} !== 2'b11) begin
            n_bad++; $display("FAIL reprime: got %b want 11", {active, black_line});
        end
        m_g = 2; m_b = 3;
    endtask

    task automatic test_cfg();
        for (int l = 0; l < 4; l++) begin
            if (l == 2) begin
                cfg_g_dly = 2'd3; cfg_b_dly = 2'd1;
            end
            send_words(160, l == 3, 1'b0);
        end
        n_cmp++;
        if (err !== 4'b1100) begin
            n_bad++; $display("FAIL cfg_refused_err: got %b want 1100", err);
        end
        n_cmp++;
        if ({fifo_flush, g_occ, b_occ} !== {1'b1, 23'd0}) begin
            n_bad++;
            $display("FAIL cfg_frame_flush: got flush=%b g=%0d b=%0d want 1/0/0", fifo_flush, g_occ, b_occ);
        end
        idle(1);
        n_cmp++;
        if (fifo_flush !== 1'b0) begin
            n_bad++; $display("FAIL flush_one_cycle: got %b want 0", fifo_flush);
        end
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        n_cmp++;
        if (err !== 4'b0000) begin
            n_bad++; $display("FAIL err_clr: got %b want 0000", err);
        end
        cfg_g_dly = 2'd1; cfg_b_dly = 2'd3;
    endtask

    task automatic test_stall();
        send_words(4 * 160 + 80, 1'b0, 1'b0);
        vld_i = 1'b1; ds_rdy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({active, black_line, r_use, g_wr, b_wr, g_rd, b_rd, line_cnt} !== {7'b1000000, 10'd4}) begin
                n_bad++;
                $display("FAIL stall_quiet cyc %0d: got flags=%b line=%0d want 1000000/4", i,
                         {active, black_line, r_use, g_wr, b_wr, g_rd, b_rd}, line_cnt);
            end
            @(posedge clk); #1;
        end
        vld_i = 1'b0; ds_rdy = 1'b1;
        n_cmp++;
        if ({g_occ, b_occ} !== {11'd320, 12'd480}) begin
            n_bad++; $display("FAIL stall_occ: got g=%0d b=%0d want 320/480", g_occ, b_occ);
        end
        send_words(80, 1'b0, 1'b0);
    endtask

    task automatic test_drift();
        send_words(101, 1'b1, 1'b0);
        n_cmp++;
        if (err !== 4'b1000) begin
            n_bad++; $display("FAIL drift_err: got %b want 1000", err);
        end
        n_cmp++;
        if ({fifo_flush, g_occ, b_occ, active, black_line} !== {1'b1, 23'd0, 2'b11}) begin
            n_bad++;
            $display("FAIL drift_flush: got flush=%b g=%0d b=%0d act=%b blk=%b want 1/0/0/1/1",
                     fifo_flush, g_occ, b_occ, active, black_line);
        end
        idle(1);
        n_cmp++;
        if (fifo_flush !== 1'b0) begin
            n_bad++; $display("FAIL drift_flush_len: got %b want 0", fifo_flush);
        end
        m_g = 1; m_b = 3;
    endtask

    task automatic test_en_clear();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        n_cmp++;
        if (err !== 4'b0000) begin
            n_bad++; $display("FAIL pre_clear: got %b want 0000", err);
        end
        for (int l = 0; l < 4; l++) begin
            if (l == 1) en = 1'b0;
            send_words(160, l == 3, l == 3);
        end
        m_act = 1'b0;
        n_cmp++;
        if (err !== 4'b1000) begin
            n_bad++; $display("FAIL set_beats_clr: got %b want 1000", err);
        end
        n_cmp++;
        if ({active, fifo_flush, g_occ, b_occ} !== {2'b01, 23'd0}) begin
            n_bad++;
            $display("FAIL to_bypass: got act=%b flush=%b g=%0d b=%0d want 0/1/0/0",
                     active, fifo_flush, g_occ, b_occ);
        end
        idle(1);
        n_cmp++;
        if ({active, fifo_flush} !== 2'b00) begin
            n_bad++; $display("FAIL bypass_settle: got %b want 00", {active, fifo_flush});
        end
        send_words(20, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_cfg();
        test_stall();
        test_drift();
        test_en_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        n_bad++;
        $display("FAIL watchdog: run still going at time %0t, want finished", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
